// File: rtl/pong_pkg.sv
// Shared constants, FSM encoding and small helpers for the pong game-state engine.
package pong_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int PAD_W        = 10;
    localparam int PAD_H        = 80;
    localparam int BALL_SZ      = 10;
    localparam int P1_X         = 20;
    localparam int P2_X         = 610;
    localparam int PAD_SPEED    = 4;
    localparam int BALL_SPEED   = 2;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 9;

    localparam int PAD_Y0  = (V_ACTIVE - PAD_H) / 2;
    localparam int BALL_X0 = (H_ACTIVE - BALL_SZ) / 2;
    localparam int BALL_Y0 = (V_ACTIVE - BALL_SZ) / 2;

    typedef enum logic [1:0] {
        ST_SERVE    = 2'd0,
        ST_PLAY     = 2'd1,
        ST_POINT    = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    // dx: 1 = moving right, dy: 1 = moving down
    localparam logic DIR_FWD  = 1'b1;
    localparam logic DIR_BACK = 1'b0;

    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: saturating vertical motion on frame ticks, recentred on restart.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int PAD_SPEED = 4,
    parameter int PAD_H     = 80,
    parameter int V_ACTIVE  = 480,
    parameter int Y0        = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       en,
    input  logic       center,
    input  logic       up,
    input  logic       dn,
    output logic [9:0] y
);

    localparam logic [10:0] SPD   = 11'(PAD_SPEED);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - PAD_H);

    logic [10:0] y_ext;
    logic [9:0]  y_next;

    always_comb begin
        y_ext  = ext11(y);
        y_next = y;
        if (up && !dn) begin
            y_next = (y_ext < SPD) ? 10'd0 : 10'(y_ext - SPD);
        end else if (dn && !up) begin
            y_next = (y_ext + SPD > Y_MAX) ? 10'(Y_MAX) : 10'(y_ext + SPD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y <= 10'(Y0);
        end else if (center) begin
            y <= 10'(Y0);
        end else if (tick && en) begin
            y <= y_next;
        end
    end

endmodule

// File: rtl/pong_game_logic.sv
// Frame-rate pong engine: synchronises vsync and buttons, then steps paddles,
// ball, scores and the serve/play/point/game-over sequence once per frame.
module pong_game_logic
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic       start,
    output logic [9:0] x1,
    output logic [9:0] y1,
    output logic [9:0] x2,
    output logic [9:0] y2,
    output logic [9:0] xb,
    output logic [9:0] yb,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over
);

    localparam logic [10:0] HA     = 11'(H_ACTIVE);
    localparam logic [10:0] VA     = 11'(V_ACTIVE);
    localparam logic [10:0] SZ     = 11'(BALL_SZ);
    localparam logic [10:0] SPD    = 11'(BALL_SPEED);
    localparam logic [10:0] PH     = 11'(PAD_H);
    localparam logic [10:0] L_FACE = 11'(P1_X + PAD_W);
    localparam logic [10:0] R_FACE = 11'(P2_X);
    localparam logic [5:0]  SERVE_LAST = 6'(SERVE_FRAMES - 1);
    localparam logic [3:0]  WIN    = 4'(WIN_SCORE);

    state_t      state, state_n;
    logic [1:0]  vs_sr;
    logic        vs_prev;
    logic [4:0]  btn_meta, btn_sync;
    logic        start_prev;
    logic        tick, start_rise, restart, pad_en;
    logic [5:0]  cnt;
    logic        dx, dy, dx_n, dy_n;
    logic [9:0]  xb_n, yb_n;
    logic [10:0] bx, by, py1, py2;
    logic        ov1, ov2, left_miss, right_miss, win;

    // vsync idles high, so its synchroniser resets high to avoid a false tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_sr      <= 2'b11;
            vs_prev    <= 1'b1;
            btn_meta   <= '0;
            btn_sync   <= '0;
            start_prev <= 1'b0;
        end else begin
            vs_sr      <= {vs_sr[0], vsync};
            vs_prev    <= vs_sr[1];
            btn_meta   <= {start, p2_dn, p2_up, p1_dn, p1_up};
            btn_sync   <= btn_meta;
            start_prev <= btn_sync[4];
        end
    end

    assign tick       = vs_prev && !vs_sr[1];
    assign start_rise = btn_sync[4] && !start_prev;
    assign restart    = (state == ST_GAMEOVER) && start_rise;
    assign pad_en     = (state == ST_SERVE) || (state == ST_PLAY);
    assign x1         = 10'(P1_X);
    assign x2         = 10'(P2_X);

    pong_paddle #(.PAD_SPEED(PAD_SPEED), .PAD_H(PAD_H), .V_ACTIVE(V_ACTIVE), .Y0(PAD_Y0)) u_pad1 (
        .clk(clk), .rst(rst), .tick(tick), .en(pad_en), .center(restart),
        .up(btn_sync[0]), .dn(btn_sync[1]), .y(y1)
    );

    pong_paddle #(.PAD_SPEED(PAD_SPEED), .PAD_H(PAD_H), .V_ACTIVE(V_ACTIVE), .Y0(PAD_Y0)) u_pad2 (
        .clk(clk), .rst(rst), .tick(tick), .en(pad_en), .center(restart),
        .up(btn_sync[2]), .dn(btn_sync[3]), .y(y2)
    );

    // Ball step for a PLAY tick; collisions use the paddle positions before the tick
    always_comb begin
        bx  = ext11(xb);
        by  = ext11(yb);
        py1 = ext11(y1);
        py2 = ext11(y2);
        ov1 = (by + SZ > py1) && (by < py1 + PH);
        ov2 = (by + SZ > py2) && (by < py2 + PH);

        yb_n = yb;
        dy_n = dy;
        if (dy == DIR_BACK) begin
            if (by < SPD) begin
                yb_n = 10'd0;
                dy_n = DIR_FWD;
            end else begin
                yb_n = 10'(by - SPD);
            end
        end else if (by + SZ + SPD > VA) begin
            yb_n = 10'(VA - SZ);
            dy_n = DIR_BACK;
        end else begin
            yb_n = 10'(by + SPD);
        end

        xb_n       = xb;
        dx_n       = dx;
        left_miss  = 1'b0;
        right_miss = 1'b0;
        if (dx == DIR_BACK) begin
            if (bx < SPD) begin
                xb_n      = 10'd0;
                left_miss = 1'b1;
            end else if (bx >= L_FACE && bx - SPD <= L_FACE && ov1) begin
                xb_n = 10'(L_FACE);
                dx_n = DIR_FWD;
            end else begin
                xb_n = 10'(bx - SPD);
            end
        end else begin
            if (bx + SZ + SPD > HA) begin
                xb_n       = 10'(HA - SZ);
                right_miss = 1'b1;
            end else if (bx + SZ <= R_FACE && bx + SZ + SPD >= R_FACE && ov2) begin
                xb_n = 10'(R_FACE - SZ);
                dx_n = DIR_BACK;
            end else begin
                xb_n = 10'(bx + SPD);
            end
        end
    end

    // After a miss dx already points at the loser, so it also names the scorer
    assign win = (dx == DIR_FWD) ? (score1 == WIN) : (score2 == WIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_SERVE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_SERVE:    if (tick && cnt == SERVE_LAST) state_n = ST_PLAY;
            ST_PLAY:     if (tick && (left_miss || right_miss)) state_n = ST_POINT;
            ST_POINT:    if (tick) state_n = win ? ST_GAMEOVER : ST_SERVE;
            ST_GAMEOVER: if (start_rise) state_n = ST_SERVE;
            default:     state_n = ST_SERVE;
        endcase
    end

    always_comb begin
        game_over = (state == ST_GAMEOVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xb     <= 10'(BALL_X0);
            yb     <= 10'(BALL_Y0);
            dx     <= DIR_FWD;
            dy     <= DIR_FWD;
            cnt    <= '0;
            score1 <= '0;
            score2 <= '0;
        end else if (restart) begin
            xb     <= 10'(BALL_X0);
            yb     <= 10'(BALL_Y0);
            dx     <= DIR_FWD;
            dy     <= DIR_FWD;
            cnt    <= '0;
            score1 <= '0;
            score2 <= '0;
        end else if (tick) begin
            case (state)
                ST_SERVE: cnt <= (cnt == SERVE_LAST) ? 6'd0 : cnt + 6'd1;
                ST_PLAY: begin
                    xb <= xb_n;
                    yb <= yb_n;
                    dx <= dx_n;
                    dy <= dy_n;
                    if (left_miss)  score2 <= score2 + 4'd1;
                    if (right_miss) score1 <= score1 + 4'd1;
                end
                ST_POINT: begin
                    if (!win) begin
                        cnt <= '0;
                        xb  <= 10'(BALL_X0);
                        yb  <= 10'(BALL_Y0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_logic.sv
// Directed bench for pong_game_logic: frames are driven on vsync, expected
// snapshots are queued per frame and compared after each frame tick.
module tb_pong_game_logic;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = 1'b1;
    logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic       start = 1'b0;
    logic [9:0] x1, y1, x2, y2, xb, yb;
    logic [3:0] score1, score2;
    logic       game_over;

    localparam logic [2:0] MP = 3'b001;  // paddles
    localparam logic [2:0] MB = 3'b010;  // ball
    localparam logic [2:0] MS = 3'b100;  // scores and game_over
    localparam logic [2:0] MA = 3'b111;
    localparam int W = 52;

    typedef struct packed {
        logic [2:0] mask;
        logic [9:0] y1, y2, xb, yb;
        logic [3:0] s1, s2;
        logic       go;
    } exp_t;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int tcount = 0;

    always #10 clk = ~clk;

    pong_game_logic dut (
        .clk(clk), .rst(rst), .vsync(vsync),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn), .start(start),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .xb(xb), .yb(yb),
        .score1(score1), .score2(score2), .game_over(game_over)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp_v, tcount);
        end
    endtask

    task automatic check_now(input int ey1, ey2, exb, eyb, es1, es2, ego);
        chk("x1", x1, 16'd20);
        chk("x2", x2, 16'd610);
        chk("y1", y1, 16'(ey1));
        chk("y2", y2, 16'(ey2));
        chk("xb", xb, 16'(exb));
        chk("yb", yb, 16'(eyb));
        chk("score1", score1, 16'(es1));
        chk("score2", score2, 16'(es2));
        chk("game_over", game_over, 16'(ego));
    endtask

    // Monitor: every vsync fall yields one tick; outputs settle 3 clk edges later
    initial begin
        exp_t e;
        forever begin
            @(negedge vsync);
            repeat (3) @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor_underflow: got tick %0d expected a queued entry", tcount);
            end else begin
                e = exp_q.pop_front();
                if (e.mask[0]) begin
                    chk("x1", x1, 16'd20);
                    chk("x2", x2, 16'd610);
                    chk("y1", y1, 16'(e.y1));
                    chk("y2", y2, 16'(e.y2));
                end
                if (e.mask[1]) begin
                    chk("xb", xb, 16'(e.xb));
                    chk("yb", yb, 16'(e.yb));
                end
                if (e.mask[2]) begin
                    chk("score1", score1, 16'(e.s1));
                    chk("score2", score2, 16'(e.s2));
                    chk("game_over", game_over, 16'(e.go));
                end
            end
        end
    end

    task automatic push_exp(input logic [2:0] mask, input int ey1, ey2, exb, eyb, es1, es2, ego);
        exp_t e;
        e.mask = mask;
        e.y1 = 10'(ey1);
        e.y2 = 10'(ey2);
        e.xb = 10'(exb);
        e.yb = 10'(eyb);
        e.s1 = 4'(es1);
        e.s2 = 4'(es2);
        e.go = ego[0];
        exp_q.push_back(e);
        tcount++;
    endtask

    task automatic frame(input int low_clks, input logic [2:0] mask,
                         input int ey1, ey2, exb, eyb, es1, es2, ego);
        push_exp(mask, ey1, ey2, exb, eyb, es1, es2, ego);
        @(negedge clk) vsync = 1'b0;
        repeat (low_clks) @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic tick_chk(input logic [2:0] mask, input int ey1, ey2, exb, eyb, es1, es2, ego);
        frame(3, mask, ey1, ey2, exb, eyb, es1, es2, ego);
    endtask

    task automatic adv_to(input int target);
        while (tcount < target - 1) frame(3, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        #1;
        check_now(200, 200, 315, 235, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tcount = 0;
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        check_now(200, 200, 315, 235, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Paddles: saturate at both ends, both-pressed holds
        p1_up = 1'b1;
        p2_dn = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            tick_chk(MP, (200 - 4 * t < 0) ? 0 : 200 - 4 * t, (200 + 4 * t > 400) ? 400 : 200 + 4 * t,
                     0, 0, 0, 0, 0);
        end
        p1_up = 1'b0;
        p2_dn = 1'b0;
        p1_dn = 1'b1;
        for (int t = 1; t <= 5; t++) tick_chk(MP, 4 * t, 400, 0, 0, 0, 0, 0);
        p1_up = 1'b1;
        for (int t = 1; t <= 3; t++) tick_chk(MP, 20, 400, 0, 0, 0, 0, 0);
        p1_up = 1'b0;
        p1_dn = 1'b0;
        p2_up = 1'b1;
        tick_chk(MP, 20, 396, 0, 0, 0, 0, 0);
        tick_chk(MP, 20, 392, 0, 0, 0, 0, 0);
        p2_up = 1'b0;

        // Reset mid-play, serve hold and launch
        do_reset();
        for (int t = 1; t <= 60; t++) tick_chk(MA, 200, 200, 315, 235, 0, 0, 0);
        tick_chk(MA, 200, 200, 317, 237, 0, 0, 0);
        tick_chk(MA, 200, 200, 319, 239, 0, 0, 0);

        // Rally: bottom bounce, right hit, left hit, right hit, left miss
        do_reset();
        p1_up = 1'b1;
        p2_dn = 1'b1;
        for (int t = 1; t <= 25; t++) tick_chk(MP, 200 - 4 * t, 200 + 4 * t, 0, 0, 0, 0, 0);
        p1_up = 1'b0;
        for (int t = 26; t <= 50; t++) tick_chk(MP, 100, 200 + 4 * t, 0, 0, 0, 0, 0);
        p2_dn = 1'b0;
        adv_to(60);
        tick_chk(MA, 100, 400, 315, 235, 0, 0, 0);
        adv_to(176);
        tick_chk(MB, 0, 0, 547, 467, 0, 0, 0);
        tick_chk(MB, 0, 0, 549, 469, 0, 0, 0);
        tick_chk(MB, 0, 0, 551, 470, 0, 0, 0);
        tick_chk(MB, 0, 0, 553, 468, 0, 0, 0);
        adv_to(202);
        tick_chk(MB, 0, 0, 599, 422, 0, 0, 0);
        tick_chk(MB, 0, 0, 600, 420, 0, 0, 0);
        tick_chk(MB, 0, 0, 598, 418, 0, 0, 0);
        adv_to(487);
        tick_chk(MB, 0, 0, 32, 146, 0, 0, 0);
        tick_chk(MB, 0, 0, 30, 148, 0, 0, 0);
        tick_chk(MB, 0, 0, 32, 150, 0, 0, 0);
        adv_to(520);
        p2_up = 1'b1;
        for (int i = 1; i <= 50; i++) tick_chk(MP, 100, 400 - 4 * i, 0, 0, 0, 0, 0);
        p2_up = 1'b0;
        adv_to(772);
        tick_chk(MB, 0, 0, 598, 226, 0, 0, 0);
        tick_chk(MB, 0, 0, 600, 224, 0, 0, 0);
        adv_to(1057);
        tick_chk(MB, 0, 0, 32, 342, 0, 0, 0);
        tick_chk(MB, 0, 0, 30, 344, 0, 0, 0);
        tick_chk(MB, 0, 0, 28, 346, 0, 0, 0);
        adv_to(1074);
        tick_chk(MA, 100, 200, 0, 376, 0, 1, 0);
        tick_chk(MA, 100, 200, 315, 235, 0, 1, 0);
        adv_to(1135);
        tick_chk(MB, 0, 0, 315, 235, 0, 0, 0);
        tick_chk(MB, 0, 0, 313, 237, 0, 0, 0);

        // Nine right misses reach game over; everything frozen; start restarts
        do_reset();
        adv_to(218);
        tick_chk(MA, 200, 200, 630, 390, 1, 0, 0);
        tick_chk(MA, 200, 200, 315, 235, 1, 0, 0);
        adv_to(437);
        tick_chk(MB | MS, 0, 0, 630, 80, 2, 0, 0);
        adv_to(1970);
        tick_chk(MA, 200, 200, 630, 390, 9, 0, 0);
        tick_chk(MA, 200, 200, 630, 390, 9, 0, 1);
        p1_up = 1'b1;
        p2_dn = 1'b1;
        tick_chk(MA, 200, 200, 630, 390, 9, 0, 1);
        tick_chk(MA, 200, 200, 630, 390, 9, 0, 1);
        p1_up = 1'b0;
        p2_dn = 1'b0;
        @(negedge clk) start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_now(200, 200, 315, 235, 0, 0, 0);
        tcount = 0;
        for (int t = 1; t <= 60; t++) tick_chk(MA, 200, 200, 315, 235, 0, 0, 0);
        tick_chk(MA, 200, 200, 317, 237, 0, 0, 0);
        @(negedge clk) start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        tick_chk(MA, 200, 200, 319, 239, 0, 0, 0);

        // vsync pulse widths and tick latency
        do_reset();
        p1_dn = 1'b1;
        repeat (3) @(negedge clk);
        push_exp(MP, 204, 200, 0, 0, 0, 0, 0);
        @(negedge clk) vsync = 1'b0;
        @(negedge clk) vsync = 1'b1;
        @(posedge clk);
        #1;
        chk("latency_before_3rd_edge", y1, 16'd200);
        repeat (3) @(negedge clk);
        frame(1000, MP, 208, 200, 0, 0, 0, 0, 0);
        chk("long_low_single_tick", y1, 16'd208);
        tick_chk(MP, 212, 200, 0, 0, 0, 0, 0);
        p1_dn = 1'b0;

        repeat (4) @(negedge clk);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
